hazard_ctrl: RTL and testbench

- Pipeline hazard and sequencing controller for the 5-stage core.
- Decides each cycle whether the PC and the FeDe/DeEx/ExMe/MeWb pipeline registers advance, hold, or take a bubble.
- Covers load-use hazards that the forwarding unit cannot resolve, taken-branch squashes, and multi-cycle memory waits.
- Sits beside the forwarding unit and drives the stall/flush enables of every pipeline register; exports saturating stall/flush performance counters.

---
 rtl/hazard_ctrl_if.sv | 42 ++++
 rtl/hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-status and stall/flush control bundle for hazard_ctrl
interface hazard_ctrl_if #(
  parameter int PERF_W = 32
);
  logic [4:0]        FeDe_reg_1_sel;
  logic [4:0]        FeDe_reg_2_sel;
  logic              FeDe_reg_1_used;
  logic              FeDe_reg_2_used;
  logic              DeEx_mem_read;
  logic              DeEx_reg_write_en;
  logic [4:0]        DeEx_reg_wrt_sel;
  logic              Ex_branch_taken;
  logic              Me_mem_req;
  logic              Me_mem_ready;
  logic              pc_write_en;
  logic              FeDe_stall;
  logic              FeDe_flush;
  logic              DeEx_stall;
  logic              DeEx_flush;
  logic              ExMe_stall;
  logic              MeWb_flush;
  logic [1:0]        state_o;
  logic [PERF_W-1:0] stall_cycles;
  logic [PERF_W-1:0] flush_events;

  // master: the pipeline datapath; slave: the hazard controller
  modport master (
    output FeDe_reg_1_sel, FeDe_reg_2_sel, FeDe_reg_1_used, FeDe_reg_2_used,
    output DeEx_mem_read, DeEx_reg_write_en, DeEx_reg_wrt_sel,
    output Ex_branch_taken, Me_mem_req, Me_mem_ready,
    input  pc_write_en, FeDe_stall, FeDe_flush, DeEx_stall, DeEx_flush,
    input  ExMe_stall, MeWb_flush, state_o, stall_cycles, flush_events
  );

  modport slave (
    input  FeDe_reg_1_sel, FeDe_reg_2_sel, FeDe_reg_1_used, FeDe_reg_2_used,
    input  DeEx_mem_read, DeEx_reg_write_en, DeEx_reg_wrt_sel,
    input  Ex_branch_taken, Me_mem_req, Me_mem_ready,
    output pc_write_en, FeDe_stall, FeDe_flush, DeEx_stall, DeEx_flush,
    output ExMe_stall, MeWb_flush, state_o, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush sequencing for the 5-stage core with saturating perf counters
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int PERF_W       = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t              state_q, state_d;
  state_t              ret_q, ret_d;
  state_t              eff_state;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PERF_W-1:0]   stall_q, stall_d;
  logic [PERF_W-1:0]   flush_q, flush_d;

  logic mem_stall, lu, hit_1, hit_2, flush_evt;
  logic pc_we, fd_stall, fd_flush, de_stall, de_flush, em_stall, mw_flush;

  assign mem_stall = bus.Me_mem_req & ~bus.Me_mem_ready;
  assign hit_1     = bus.FeDe_reg_1_used & (bus.FeDe_reg_1_sel == bus.DeEx_reg_wrt_sel);
  assign hit_2     = bus.FeDe_reg_2_used & (bus.FeDe_reg_2_sel == bus.DeEx_reg_wrt_sel);
  assign lu        = bus.DeEx_mem_read & bus.DeEx_reg_write_en &
                     (bus.DeEx_reg_wrt_sel != 5'd0) & (hit_1 | hit_2);

  // A released memory wait behaves, in its release cycle, like the state it interrupted.
  assign eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

  always_comb begin
    pc_we     = 1'b1;
    fd_stall  = 1'b0;
    fd_flush  = 1'b0;
    de_stall  = 1'b0;
    de_flush  = 1'b0;
    em_stall  = 1'b0;
    mw_flush  = 1'b0;
    flush_evt = 1'b0;
    state_d   = state_q;
    ret_d     = ret_q;
    cnt_d     = cnt_q;

    if (rst) begin
      pc_we    = 1'b0;
      fd_flush = 1'b1;
      de_flush = 1'b1;
      mw_flush = 1'b1;
      state_d  = RUN;
      ret_d    = RUN;
      cnt_d    = '0;
    end else if (mem_stall) begin
      pc_we    = 1'b0;
      fd_stall = 1'b1;
      de_stall = 1'b1;
      em_stall = 1'b1;
      mw_flush = 1'b1;
      state_d  = MEM_WAIT;
      if (state_q != MEM_WAIT) begin
        ret_d = state_q;
      end
    end else begin
      case (eff_state)
        RUN: begin
          state_d = RUN;
          if (bus.Ex_branch_taken) begin
            fd_flush  = 1'b1;
            de_flush  = 1'b1;
            flush_evt = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              cnt_d   = CW'(FLUSH_CYCLES - 1);
              state_d = FLUSH;
            end
          end else if (lu) begin
            pc_we    = 1'b0;
            fd_stall = 1'b1;
            de_flush = 1'b1;
          end
        end
        FLUSH: begin
          fd_flush = 1'b1;
          cnt_d    = cnt_q - 1'b1;
          state_d  = (cnt_q == CW'(1)) ? RUN : FLUSH;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (rst) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (!pc_we && !(&stall_q)) begin
        stall_d = stall_q + PERF_W'(1);
      end
      if (flush_evt && !(&flush_q)) begin
        flush_d = flush_q + PERF_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ret_q   <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.pc_write_en  = pc_we;
  assign bus.FeDe_stall   = fd_stall;
  assign bus.FeDe_flush   = fd_flush;
  assign bus.DeEx_stall   = de_stall;
  assign bus.DeEx_flush   = de_flush;
  assign bus.ExMe_stall   = em_stall;
  assign bus.MeWb_flush   = mw_flush;
  assign bus.state_o      = state_q;
  assign bus.stall_cycles = stall_q;
  assign bus.flush_events = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl against a cycle-level behavioural model
module tb_hazard_ctrl;
  localparam int FC     = 3;
  localparam int PW     = 6;
  localparam int PMAX   = (1 << PW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.PERF_W(PW)) bus ();

  hazard_ctrl #(.FLUSH_CYCLES(FC), .PERF_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit pc, fs, ff, ds, df, es, mf;
    int st, sc, fe;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  // model: mode 0 = running, 1 = squashing (left slots remain), 2 = waiting on memory
  int m_mode = 0, m_left = 0, m_resume = 0, m_sc = 0, m_fe = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input int r1, input int r2, input bit u1, input bit u2,
                      input bit mr, input bit we, input int ws, input bit br,
                      input bit req, input bit rdy);
    exp_t e;
    bit stall_mem, hazard;
    int mode;
    @(posedge clk);
    #1;
    rst                   = r;
    bus.FeDe_reg_1_sel    = 5'(r1);
    bus.FeDe_reg_2_sel    = 5'(r2);
    bus.FeDe_reg_1_used   = u1;
    bus.FeDe_reg_2_used   = u2;
    bus.DeEx_mem_read     = mr;
    bus.DeEx_reg_write_en = we;
    bus.DeEx_reg_wrt_sel  = 5'(ws);
    bus.Ex_branch_taken   = br;
    bus.Me_mem_req        = req;
    bus.Me_mem_ready      = rdy;

    e = '{pc: 1, fs: 0, ff: 0, ds: 0, df: 0, es: 0, mf: 0, st: m_mode, sc: m_sc, fe: m_fe};
    stall_mem = req && !rdy;
    hazard    = mr && we && ws != 0 && ((u1 && r1 == ws) || (u2 && r2 == ws));
    if (r) begin
      e.pc = 0; e.ff = 1; e.df = 1; e.mf = 1;
      m_mode = 0; m_left = 0; m_resume = 0; m_sc = 0; m_fe = 0;
    end else begin
      if (stall_mem) begin
        e.pc = 0; e.fs = 1; e.ds = 1; e.es = 1; e.mf = 1;
        if (m_mode != 2) m_resume = m_mode;
        m_mode = 2;
      end else begin
        mode = (m_mode == 2) ? m_resume : m_mode;
        if (mode == 1) begin
          e.ff = 1;
          m_mode = (m_left == 1) ? 0 : 1;
          m_left = m_left - 1;
        end else begin
          m_mode = 0;
          if (br) begin
            e.ff = 1; e.df = 1;
            if (m_fe < PMAX) m_fe++;
            if (FC > 1) begin m_mode = 1; m_left = FC - 1; end
          end else if (hazard) begin
            e.pc = 0; e.fs = 1; e.df = 1;
          end
        end
      end
      if (!e.pc && m_sc < PMAX) m_sc++;
    end
    sb.push_back(e);
  endtask

  task automatic idle(input bit r);
    step(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic mem(input bit req, input bit rdy, input bit br);
    step(0, 0, 0, 0, 0, 0, 0, 0, br, req, rdy);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pc_write_en",  int'(bus.pc_write_en),  int'(e.pc));
      chk("FeDe_stall",   int'(bus.FeDe_stall),   int'(e.fs));
      chk("FeDe_flush",   int'(bus.FeDe_flush),   int'(e.ff));
      chk("DeEx_stall",   int'(bus.DeEx_stall),   int'(e.ds));
      chk("DeEx_flush",   int'(bus.DeEx_flush),   int'(e.df));
      chk("ExMe_stall",   int'(bus.ExMe_stall),   int'(e.es));
      chk("MeWb_flush",   int'(bus.MeWb_flush),   int'(e.mf));
      chk("state_o",      int'(bus.state_o),      e.st);
      chk("stall_cycles", int'(bus.stall_cycles), e.sc);
      chk("flush_events", int'(bus.flush_events), e.fe);
    end
  end

  initial begin
    bus.FeDe_reg_1_sel = '0; bus.FeDe_reg_2_sel = '0;
    bus.FeDe_reg_1_used = 0; bus.FeDe_reg_2_used = 0;
    bus.DeEx_mem_read = 0; bus.DeEx_reg_write_en = 0; bus.DeEx_reg_wrt_sel = '0;
    bus.Ex_branch_taken = 0; bus.Me_mem_req = 0; bus.Me_mem_ready = 0;

    idle(1); idle(1); idle(0);
    // load-use on r5, then the bubble cycle, then the same load to r0
    step(0, 5, 0, 1, 0, 1, 1, 5, 0, 0, 0);
    idle(0);
    @(negedge clk); #1 chk("lu_stall_count", int'(bus.stall_cycles), 1);
    step(0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0);
    idle(0);
    // taken branch with a three-cycle squash window
    mem(0, 0, 1); idle(0); idle(0); idle(0);
    @(negedge clk); #1 chk("branch_flush_count", int'(bus.flush_events), 1);
    // four-cycle memory wait
    repeat (4) mem(1, 0, 0);
    mem(1, 1, 0); idle(0);
    @(negedge clk); #1 chk("memwait_stall_count", int'(bus.stall_cycles), 5);
    // memory stall, branch and load-use together; branch still up on release
    step(0, 7, 0, 1, 0, 1, 1, 7, 1, 1, 0);
    step(0, 7, 0, 1, 0, 1, 1, 7, 1, 1, 1);
    idle(0); idle(0); idle(0);
    // memory wait inside the squash window
    mem(0, 0, 1); mem(1, 0, 0); mem(1, 0, 0); mem(1, 1, 0); idle(0); idle(0); idle(0);
    // reset while waiting on memory
    mem(1, 0, 0); step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); idle(1); idle(0);
    @(negedge clk); #1 chk("reset_stall_count", int'(bus.stall_cycles), 0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 3), $urandom_range(0, 3),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 3),
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0, 1'($urandom));
    end
    idle(0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
